mem_traffic_initiator: RTL

Request-side counterpart of the memory controller front-end. Drives the write and read request ports (`wr_address/wr_en/wr_data`, `rd_address/rd_en`) and consumes the tagged return channels (`wr_ret_*`, `rd_ret_*`). It issues a programmed sweep of writes, then reads back the same addresses, and checks returned data against a fixed pattern. A credit counter bounds the number of outstanding requests. Used as the traffic source and self-checker in front of the controller in simulation.

---
 rtl/mem_traffic_initiator.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_traffic_initiator.sv
// mem_traffic_initiator: credit-limited write sweep followed by a read-back sweep,
// checking returned data and tags against the addr ^ 16'hA5A5 pattern.
module mem_traffic_initiator #(
    parameter int          NUM_REQ         = 16,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [15:0] BASE_ADDR       = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [15:0] wr_address,
    output logic        wr_en,
    output logic [15:0] wr_data,
    input  logic [15:0] wr_ret_address,
    input  logic        wr_ret_ack,
    output logic [15:0] rd_address,
    output logic        rd_en,
    input  logic [15:0] rd_ret_data,
    input  logic [15:0] rd_ret_address,
    input  logic        rd_ret_ack,
    output logic        busy,
    output logic        done,
    output logic [15:0] err_count,
    output logic [15:0] last_err_addr
);
    typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_DRAIN, RD_ISSUE, RD_DRAIN, DONE} state_t;
    localparam logic [16:0] NREQ  = 17'(NUM_REQ);
    localparam logic [8:0]  NLAST = 9'(NUM_REQ - 1);
    localparam logic [8:0]  NACK  = 9'(NUM_REQ);
    localparam logic [3:0]  MAXO  = 4'(MAX_OUTSTANDING);
    localparam logic [15:0] PAT   = 16'hA5A5;

    state_t      state_q, state_d;
    logic [8:0]  idx_q, idx_d, ack_q, ack_d;
    logic [3:0]  out_q, out_d;
    logic        wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic [15:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d, rd_addr_q, rd_addr_d;
    logic [15:0] err_q, err_d, last_q, last_d;
    logic        wr_phase, rd_phase, wr_in, rd_in, wr_err, rd_err, comp, issue;
    logic [15:0] cur_addr, wr_off, rd_off;
    logic [16:0] err_sum;

    always_comb begin
        wr_phase = state_q == WR_ISSUE || state_q == WR_DRAIN;
        rd_phase = state_q == RD_ISSUE || state_q == RD_DRAIN;
        wr_off   = wr_ret_address - BASE_ADDR;
        rd_off   = rd_ret_address - BASE_ADDR;
        wr_in    = {1'b0, wr_off} < NREQ;
        rd_in    = {1'b0, rd_off} < NREQ;
        wr_err   = wr_ret_ack && (!wr_phase || !wr_in || out_q == 4'd0);
        rd_err   = rd_ret_ack && (!rd_phase || !rd_in || out_q == 4'd0 ||
                                  rd_ret_data != (rd_ret_address ^ PAT));
        // a data mismatch still completes the read; bad tags and spurious acks do not
        comp     = (wr_ret_ack && wr_phase && wr_in && out_q != 4'd0) ||
                   (rd_ret_ack && rd_phase && rd_in && out_q != 4'd0);
        issue    = (state_q == WR_ISSUE || state_q == RD_ISSUE) && out_q < MAXO;
        cur_addr = BASE_ADDR + {7'd0, idx_q};
        err_sum  = {1'b0, err_q} + {16'd0, wr_err} + {16'd0, rd_err};
        state_d   = state_q;
        idx_d     = issue ? idx_q + 9'd1 : idx_q;
        ack_d     = ack_q + {8'd0, comp};
        out_d     = out_q + {3'd0, issue} - {3'd0, comp};
        wr_en_d   = issue && state_q == WR_ISSUE;
        rd_en_d   = issue && state_q == RD_ISSUE;
        wr_addr_d = wr_en_d ? cur_addr : wr_addr_q;
        wr_data_d = wr_en_d ? cur_addr ^ PAT : wr_data_q;
        rd_addr_d = rd_en_d ? cur_addr : rd_addr_q;
        err_d     = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        last_d    = rd_err ? rd_ret_address : wr_err ? wr_ret_address : last_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = WR_ISSUE;
                idx_d   = '0;
                ack_d   = '0;
                out_d   = '0;
                err_d   = '0;
                last_d  = '0;
            end
            WR_ISSUE: if (issue && idx_q == NLAST) state_d = WR_DRAIN;
            WR_DRAIN: if (ack_d == NACK) begin
                state_d = RD_ISSUE;
                idx_d   = '0;
                ack_d   = '0;
                out_d   = '0;
            end
            RD_ISSUE: if (issue && idx_q == NLAST) state_d = RD_DRAIN;
            RD_DRAIN: if (ack_d == NACK) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            ack_q     <= '0;
            out_q     <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            err_q     <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ack_q     <= ack_d;
            out_q     <= out_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
            err_q     <= err_d;
            last_q    <= last_d;
        end
    end

    assign wr_en         = wr_en_q;
    assign wr_address    = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign rd_en         = rd_en_q;
    assign rd_address    = rd_addr_q;
    assign busy          = state_q != IDLE && state_q != DONE;
    assign done          = state_q == DONE;
    assign err_count     = err_q;
    assign last_err_addr = last_q;
endmodule
